// File: rtl/intt2_gs_pipeline_top.sv
// intt2_gs_pipeline_top: 4-stage Gentleman-Sande inverse-NTT butterfly with Barrett reduction.
// Optional build macro INTT_HALF_SCALE_EN scales both outputs by 2^-1 mod Q in the last stage.
module intt2_gs_pipeline_top #(
    parameter int DW = 12,
    parameter int Q  = 3329,
    parameter int K  = 2 * DW,
    parameter int M  = (2 ** K) / Q
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] xin,
    input  logic [DW-1:0] yin,
    input  logic [DW-1:0] wr,
    output logic [DW-1:0] xout,
    output logic [DW-1:0] yout,
    output logic          valid
);
    localparam int MW = $clog2(M + 1);
    localparam int PW = 2 * DW + MW;
    localparam logic [DW:0]     Q_W = (DW + 1)'(Q);
    localparam logic [DW-1:0]   Q_D = DW'(Q);
    localparam logic [PW-1:0]   M_P = PW'(M);
    localparam logic [2*DW-1:0] Q_P = (2 * DW)'(Q);

    logic            v1, v2, v3, v4;
    logic [DW-1:0]   s1, d1, w1, s2, s3, t3;
    logic [2*DW-1:0] p2, p3;

    logic [DW:0]     sum0;
    logic [DW-1:0]   sum_red, diff_red, t3_next;
    logic [2*DW-1:0] tq;
    logic [DW:0]     r4;
    logic [DW-1:0]   r4_red, x_fin, y_fin;

    // Barrett quotient estimate t3 never exceeds p2/Q, so DW bits hold it
    always_comb begin
        sum0     = {1'b0, xin} + {1'b0, yin};
        sum_red  = (sum0 >= Q_W) ? DW'(sum0 - Q_W) : sum0[DW-1:0];
        diff_red = (xin >= yin) ? (xin - yin) : (xin - yin + Q_D);
        t3_next  = DW'((PW'(p2) * M_P) >> K);
        tq       = (2 * DW)'(t3) * Q_P;
        r4       = (DW + 1)'(p3 - tq);
        r4_red   = (r4 >= Q_W) ? DW'(r4 - Q_W) : r4[DW-1:0];
    end

`ifdef INTT_HALF_SCALE_EN
    // Halving mod Q: odd values borrow one Q so the shift is exact
    function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] v);
        logic [DW:0] t;
        t = v[0] ? ({1'b0, v} + Q_W) : {1'b0, v};
        return t[DW:1];
    endfunction

    assign x_fin = half_mod(s3);
    assign y_fin = half_mod(r4_red);
`else
    assign x_fin = s3;
    assign y_fin = r4_red;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            v4   <= 1'b0;
            s1   <= '0;
            d1   <= '0;
            w1   <= '0;
            p2   <= '0;
            s2   <= '0;
            t3   <= '0;
            p3   <= '0;
            s3   <= '0;
            xout <= '0;
            yout <= '0;
        end else begin
            v1   <= en;
            v2   <= v1;
            v3   <= v2;
            v4   <= v3;
            s1   <= sum_red;
            d1   <= diff_red;
            w1   <= wr;
            p2   <= (2 * DW)'(d1) * (2 * DW)'(w1);
            s2   <= s1;
            t3   <= t3_next;
            p3   <= p2;
            s3   <= s2;
            xout <= x_fin;
            yout <= y_fin;
        end
    end

    assign valid = v4;

endmodule

// File: tb/tb_intt2_gs_pipeline_top.sv
// Self-checking bench for intt2_gs_pipeline_top: directed vector table plus randomized scoreboard run.
// Expected values follow INTT_HALF_SCALE_EN when the bench is built with that macro.
module tb_intt2_gs_pipeline_top;
    localparam int DW = 12;
    localparam int Q  = 3329;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] xin = '0;
    logic [DW-1:0] yin = '0;
    logic [DW-1:0] wr = '0;
    logic [DW-1:0] xout;
    logic [DW-1:0] yout;
    logic          valid;

    intt2_gs_pipeline_top dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .xin   (xin),
        .yin   (yin),
        .wr    (wr),
        .xout  (xout),
        .yout  (yout),
        .valid (valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, w;
        int ex, ey;
        int hx, hy;
    } vec_t;

    typedef struct {
        int due;
        int ex, ey;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];
    int   cycle = 0;
    int   checks = 0;
    int   passes = 0;
    int   en_sent = 0;
    int   valid_seen = 0;
    bit   last_reset = 1'b0;

    function automatic int scale(input longint v);
`ifdef INTT_HALF_SCALE_EN
        return int'((v * ((Q + 1) / 2)) % Q);
`else
        return int'(v % Q);
`endif
    endfunction

    // Reference butterfly straight from the modular definition
    function automatic void golden(input int x, input int y, input int w, output int gx, output int gy);
        longint d;
        d  = (longint'(x) - longint'(y) + Q) % Q;
        gx = scale((longint'(x) + longint'(y)) % Q);
        gy = scale((d * w) % Q);
    endfunction

    function automatic int pick_x(input vec_t v);
`ifdef INTT_HALF_SCALE_EN
        return v.hx;
`else
        return v.ex;
`endif
    endfunction

    function automatic int pick_y(input vec_t v);
`ifdef INTT_HALF_SCALE_EN
        return v.hy;
`else
        return v.ey;
`endif
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cycle, act, exp);
    endtask

    task automatic checkOutput(input string tag);
        bit exp_v;
        if (last_reset) begin
            check({tag, "_valid"}, int'(valid), 0);
            check({tag, "_xout"}, int'(xout), 0);
            check({tag, "_yout"}, int'(yout), 0);
        end else begin
            while (sb.size() > 0 && sb[0].due < cycle) void'(sb.pop_front());
            exp_v = (sb.size() > 0) && (sb[0].due == cycle);
            check({tag, "_valid"}, int'(valid), int'(exp_v));
            if (valid === 1'b1) valid_seen++;
            if (exp_v) begin
                check({tag, "_xout"}, int'(xout), sb[0].ex);
                check({tag, "_yout"}, int'(yout), sb[0].ey);
                void'(sb.pop_front());
            end
        end
    endtask

    // One clock: drive inputs, take the edge, record expectation, sample 1 time unit later
    task automatic applyStimulus(input bit r, input bit e, input int x, input int y, input int w,
                                 input int ex, input int ey, input string tag);
        exp_t item;
        reset = r;
        en    = e;
        xin   = DW'(x);
        yin   = DW'(y);
        wr    = DW'(w);
        @(posedge clk);
        cycle++;
        last_reset = r;
        if (r) begin
            sb.delete();
        end else if (e) begin
            item.due = cycle + 3;
            item.ex  = ex;
            item.ey  = ey;
            sb.push_back(item);
            en_sent++;
        end
        #1;
        checkOutput(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b0, $urandom_range(0, Q - 1), $urandom_range(0, Q - 1),
                          $urandom_range(0, Q - 1), 0, 0, tag);
    endtask

    initial begin
        int gx, gy, x, y, w;
        bit e;

        vecs[0] = '{5, 3, 2, 8, 4, 4, 2};
        vecs[1] = '{3, 5, 1, 8, 3327, 4, 3328};
        vecs[2] = '{3, 2, 1, 5, 1, 1667, 1665};
        vecs[3] = '{3328, 3328, 3328, 3327, 0, 3328, 0};
        vecs[4] = '{0, 3328, 3328, 3328, 3328, 1664, 1664};
        vecs[5] = '{1000, 1000, 1234, 2000, 0, 1000, 0};
        vecs[6] = '{1234, 17, 0, 1251, 0, 2290, 0};
        vecs[7] = '{1664, 1665, 7, 0, 3322, 0, 1661};
        vecs[8] = '{3328, 0, 3328, 3328, 1, 1664, 1665};

        // Reset held with en=1: everything stays cleared, then first result four edges after release
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b1, 5, 3, 2, 0, 0, "reset_hold");
        applyStimulus(1'b0, 1'b1, 5, 3, 2, pick_x(vecs[0]), pick_y(vecs[0]), "post_reset");
        idle(5, "post_reset_idle");

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, vecs[i].x, vecs[i].y, vecs[i].w,
                          pick_x(vecs[i]), pick_y(vecs[i]), $sformatf("vec%0d", i));
            idle(4, $sformatf("vec%0d_idle", i));
        end

        for (int i = 0; i < 9; i++)
            applyStimulus(1'b0, 1'b1, vecs[i].x, vecs[i].y, vecs[i].w,
                          pick_x(vecs[i]), pick_y(vecs[i]), $sformatf("b2b%0d", i));
        idle(5, "b2b_idle");

        en_sent    = 0;
        valid_seen = 0;
        while (en_sent < 1000) begin
            e = ($urandom_range(0, 99) < 70);
            x = $urandom_range(0, Q - 1);
            y = $urandom_range(0, Q - 1);
            w = $urandom_range(0, Q - 1);
            golden(x, y, w, gx, gy);
            applyStimulus(1'b0, e, x, y, w, gx, gy, "rand");
        end
        idle(6, "rand_drain");
        check("rand_valid_count", valid_seen, en_sent);

        // Reset with three results in flight: none may emerge afterwards
        for (int i = 0; i < 3; i++) begin
            x = $urandom_range(0, Q - 1);
            y = $urandom_range(0, Q - 1);
            w = $urandom_range(0, Q - 1);
            golden(x, y, w, gx, gy);
            applyStimulus(1'b0, 1'b1, x, y, w, gx, gy, "flush_fill");
        end
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 0, "flush_reset");
        idle(6, "flush_idle");
        golden(3, 2, 1, gx, gy);
        applyStimulus(1'b0, 1'b1, 3, 2, 1, gx, gy, "flush_resume");
        idle(5, "flush_resume_idle");

        check("scoreboard_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
